// File: rtl/fb_frame_writer.sv
// fb_frame_writer: write side of a double-buffered 1bpp COLSxROWS framebuffer.
//
// Packs a valid/ready byte stream (framed by s_sof) into the back bank of a
// dual-port frame RAM. Once a full frame has been written, the bank swap is
// held off until the scan side reports end of frame. This keeps the display
// from ever showing a half-written frame.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   s_data/s_sof      pixel byte (bit 7 = leftmost pixel), start-of-frame flag
//   s_valid/s_ready   input handshake
//   frame_end         one-cycle pulse from the scan side at frame wrap
//   wr_en/addr/data   registered RAM write port, addr = {bank, row, byte_idx}
//   disp_bank         bank the read side displays
//   swap_pulse        one-cycle pulse when disp_bank toggles
//   sof_err           sticky flag: s_sof seen mid-frame (cleared by rst only)
//
// Build option: define FB_BITREV_EN to bit-reverse each byte on its way to the
// RAM, for panels and RAMs wired with bit 0 as the leftmost pixel.
module fb_frame_writer #(
  parameter  int COLS = 64,
  parameter  int ROWS = 64,
  localparam int BPR  = COLS / 8,
  localparam int AW   = 1 + $clog2(ROWS) + $clog2(BPR)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    s_data,
  input  logic          s_sof,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic          frame_end,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          disp_bank,
  output logic          swap_pulse,
  output logic          sof_err
);
  localparam int CW = AW - 1;
  localparam logic [CW-1:0] LAST = CW'(ROWS * BPR - 1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WAIT} state_t;

  state_t          r_state, w_next;
  logic [CW-1:0]   r_cnt;
  logic            r_ready, r_wr_en, r_bank, r_swap, r_sof_err;
  logic [AW-1:0]   r_wr_addr;
  logic [7:0]      r_wr_data, w_wdata;
  logic            w_acc, w_wr, w_swap, w_ready_nxt;
  logic [CW-1:0]   w_wcnt;

  assign w_acc  = s_valid & r_ready;
  // r_ready is low in S_WAIT, so any accepted byte is written unless it is
  // a non-sof byte arriving while idle.
  assign w_wr   = w_acc & ((r_state == S_RECV) | s_sof);
  assign w_swap = (r_state == S_WAIT) & frame_end;
  // A sof byte always resyncs to offset 0.
  assign w_wcnt = s_sof ? '0 : r_cnt;

  always_comb begin
    w_wdata = s_data;
`ifdef FB_BITREV_EN
    for (int i = 0; i < 8; i++) w_wdata[i] = s_data[7-i];
`else
`endif
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_acc && s_sof) w_next = S_RECV;
      S_RECV: if (w_acc && !s_sof && r_cnt == LAST) w_next = S_WAIT;
      S_WAIT: if (frame_end) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    // Ready is registered from the next state. It is also held low for the
    // swap cycle itself, so the first post-swap byte lands a cycle later.
    w_ready_nxt = (w_next != S_WAIT) && !w_swap;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_ready   <= 1'b0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_bank    <= 1'b0;
      r_swap    <= 1'b0;
      r_sof_err <= 1'b0;
    end else begin
      r_ready <= w_ready_nxt;
      r_wr_en <= w_wr;
      r_swap  <= w_swap;
      if (w_swap) r_bank <= ~r_bank;
      if (w_wr) begin
        r_wr_addr <= {~r_bank, w_wcnt};
        r_wr_data <= w_wdata;
        if (s_sof)              r_cnt <= CW'(1);
        else if (r_cnt == LAST) r_cnt <= '0;
        else                    r_cnt <= r_cnt + CW'(1);
        if (s_sof && r_state == S_RECV) r_sof_err <= 1'b1;
      end
    end
  end

  assign s_ready    = r_ready;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign disp_bank  = r_bank;
  assign swap_pulse = r_swap;
  assign sof_err    = r_sof_err;
endmodule
